mem_responder: RTL and testbench

- Word-addressed memory slave that answers fetch and load/store requests issued by the core's IFU/LSU initiators.
- Uses a two-channel valid/ready handshake: a request channel and a response channel.
- Only one request is outstanding at a time.
- Response latency is fixed at LATENCY cycles.
- Sits between the core and the simulated main memory. Replaces the zero-latency combinational fetch path so the core can be moved to a multi-cycle bus.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an IFU/LSU initiator and mem_responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory slave: one outstanding request, fixed LATENCY-cycle response,
// byte-masked writes, range error for addresses outside [BASE, BASE+4*DEPTH).
module mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic        lat_wen;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] c_addr;
  logic        c_wen;
  logic [31:0] c_wdata;
  logic [3:0]  c_wmask;
  logic [31:0] word_addr;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        commit;

  // With LATENCY=1 the commit edge is the acceptance edge, so the live request is used.
  always_comb begin
    c_addr  = lat_addr;
    c_wen   = lat_wen;
    c_wdata = lat_wdata;
    c_wmask = lat_wmask;
    if (state == IDLE) begin
      c_addr  = bus.req_addr;
      c_wen   = bus.req_wen;
      c_wdata = bus.req_wdata;
      c_wmask = bus.req_wmask;
    end
  end

  assign word_addr = {c_addr[31:2], 2'b00};
  assign offset    = word_addr - BASE;
  assign idx       = offset[AW+1:2];
  assign in_range  = (word_addr >= BASE) && ((offset >> 2) < 32'(DEPTH));

  assign commit = ((LATENCY == 1) && (state == IDLE) && bus.req_valid) ||
                  ((state == WAIT) && (cnt == 4'd1));

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      lat_addr  <= '0;
      lat_wen   <= 1'b0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_addr  <= bus.req_addr;
            lat_wen   <= bus.req_wen;
            lat_wdata <= bus.req_wdata;
            lat_wmask <= bus.req_wmask;
            cnt       <= LAT_M1;
            state     <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state <= IDLE;
            err_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        err_q   <= ~in_range;
        rdata_q <= (in_range && !c_wen) ? mem[idx] : '0;
      end
    end
  end

  // Array has no reset; rst suppresses a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (commit && !rst && in_range && c_wen) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_wmask[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 instance plus a LATENCY=1 instance).
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder_if b();
  mem_responder_if b1();

  mem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .bus(b.slave)
  );

  mem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  // Issues one request on b, returns at the first cycle resp_valid is seen (lat counts
  // edges from acceptance, acceptance edge included); completes it if resp_ready is high.
  task automatic xact(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                      input logic [3:0] wmask, output logic [31:0] rdata, output logic err,
                      output int lat);
    int n;
    b.req_addr  = addr;
    b.req_wen   = wen;
    b.req_wdata = wdata;
    b.req_wmask = wmask;
    b.req_valid = 1'b1;
    n = 0;
    while (!b.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    b.req_valid = 1'b0;
    lat = (n < 20) ? 1 : 99;
    while (!b.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rdata = b.resp_rdata;
    err   = b.resp_err;
    if (b.resp_ready && b.resp_valid) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (b.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", b.req_ready); end
    checks++; if (b.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", b.resp_valid); end
    checks++; if (b.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got %h exp 0", b.resp_rdata); end
    checks++; if (b.resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %b exp 0", b.resp_err); end
    checks++; if (b1.req_ready !== 1'b1 || b1.resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_l1 got ready %b valid %b exp 1 0", b1.req_ready, b1.resp_valid); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat;
    xact(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", er); end
    checks++; if (b.resp_valid !== 1'b0 || b.req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_done got valid %b ready %b exp 0 1", b.resp_valid, b.req_ready); end
    xact(32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL rd_after_wr got %h err %b lat %0d exp deadbeef 0 2", rd, er, lat); end
  endtask

  task automatic test_byte_mask;
    logic [31:0] rd; logic er; int lat;
    xact(32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101, rd, er, lat);
    xact(32'h8000_0010, 1'b0, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'hDE22_BE44 || er !== 1'b0) begin
      errors++; $display("FAIL byte_mask got %h err %b exp de22be44 0", rd, er); end
    xact(32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    xact(32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL zero_mask_write got %h exp de22be44", rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er; int lat;
    xact(32'h8000_0000, 1'b1, 32'h0123_4567, 4'hF, rd, er, lat);
    xact(32'h7FFF_FFFC, 1'b0, 32'h0, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_below got err %b rdata %h exp 1 0", er, rd); end
    xact(32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_above got err %b rdata %h exp 1 0", er, rd); end
    xact(32'h8000_0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h0123_4567 || er !== 1'b0) begin
      errors++; $display("FAIL oor_word0 got %h err %b exp 01234567 0", rd, er); end
    xact(32'h8000_0FFE, 1'b1, 32'hA5A5_0F0F, 4'hF, rd, er, lat);
    xact(32'h8000_0FFC, 1'b0, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'hA5A5_0F0F || er !== 1'b0) begin
      errors++; $display("FAIL last_word got %h err %b exp a5a50f0f 0", rd, er); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat;
    b.resp_ready = 1'b0;
    xact(32'h8000_0010, 1'b0, 32'h0, 4'hF, rd, er, lat);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin b.req_valid = 1'b1; b.req_addr = 32'h8000_0000; end
      checks++; if (b.resp_valid !== 1'b1 || b.resp_rdata !== 32'hDE22_BE44 ||
                    b.resp_err !== 1'b0 || b.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v %b d %h e %b r %b exp 1 de22be44 0 0",
                           k, b.resp_valid, b.resp_rdata, b.resp_err, b.req_ready); end
      if (k < 2) begin @(posedge clk); #1; end
    end
    b.req_valid = 1'b0;
    @(posedge clk); #1;
    b.resp_ready = 1'b1;
    checks++; if (b.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_cycle4 got valid %b exp 1", b.resp_valid); end
    @(posedge clk); #1;
    checks++; if (b.resp_valid !== 1'b0 || b.req_ready !== 1'b1 || b.resp_rdata !== 32'hDE22_BE44) begin
      errors++; $display("FAIL bp_release got v %b r %b d %h exp 0 1 de22be44",
                         b.resp_valid, b.req_ready, b.resp_rdata); end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; logic er; int lat;
    xact(32'h8000_0020, 1'b1, 32'h55AA_55AA, 4'hF, rd, er, lat);
    xact(32'h8000_0020, 1'b0, 32'h0, 4'hF, rd, er, lat);
    b.req_addr = 32'h8000_0020; b.req_wen = 1'b1; b.req_wdata = 32'hCAFE_F00D; b.req_wmask = 4'hF;
    b.req_valid = 1'b1;
    @(posedge clk); #1;
    b.req_valid = 1'b0;
    checks++; if (b.req_ready !== 1'b0) begin errors++; $display("FAIL rw_in_wait got ready %b exp 0", b.req_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (b.resp_valid !== 1'b0 || b.req_ready !== 1'b1 || b.resp_rdata !== 32'h0 || b.resp_err !== 1'b0) begin
      errors++; $display("FAIL rw_outputs got v %b r %b d %h e %b exp 0 1 0 0",
                         b.resp_valid, b.req_ready, b.resp_rdata, b.resp_err); end
    xact(32'h8000_0020, 1'b0, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h55AA_55AA || lat !== 2) begin
      errors++; $display("FAIL rw_discard got %h lat %0d exp 55aa55aa 2", rd, lat); end
  endtask

  task automatic test_back_to_back_l1;
    int accepts = 0;
    b1.req_addr = 32'h8000_0004; b1.req_wen = 1'b1; b1.req_wdata = 32'h1234_5678; b1.req_wmask = 4'hF;
    b1.req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (b1.req_ready && b1.req_valid) accepts++;
      checks++; if (b1.req_ready !== ((k % 2) == 0) || b1.resp_valid !== ((k % 2) == 1) ||
                    b1.resp_err !== 1'b0) begin
        errors++; $display("FAIL l1_cycle%0d got r %b v %b e %b exp %b %b 0",
                           k, b1.req_ready, b1.resp_valid, b1.resp_err, (k % 2) == 0, (k % 2) == 1); end
      @(posedge clk); #1;
    end
    b1.req_valid = 1'b0;
    checks++; if (accepts !== 5) begin errors++; $display("FAIL l1_accepts got %0d exp 5", accepts); end
  endtask

  initial begin
    b.req_valid = 1'b0; b.req_addr = '0; b.req_wen = 1'b0; b.req_wdata = '0; b.req_wmask = '0;
    b.resp_ready = 1'b1;
    b1.req_valid = 1'b0; b1.req_addr = '0; b1.req_wen = 1'b0; b1.req_wdata = '0; b1.req_wmask = '0;
    b1.resp_ready = 1'b1;
    test_reset;
    test_write_read;
    test_byte_mask;
    test_out_of_range;
    test_backpressure;
    test_reset_in_wait;
    test_back_to_back_l1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
